// File: rtl/rtc_counter.sv
// rtc_counter: BCD hh:mm:ss real-time clock with field adjust, validated load and 12/24 h display.
// Optional alarm (Alarm_* ports) is built only when RTC_COUNTER_ALARM_EN is defined.
module rtc_counter #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SEC_START = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Mode_12h,
    input  logic [1:0]  Field_sel,
    input  logic        Inc,
    input  logic        Dec,
    input  logic        Load,
    input  logic [23:0] Load_time,
`ifdef RTC_COUNTER_ALARM_EN
    input  logic [23:0] Alarm_time,
    input  logic        Alarm_arm,
    input  logic        Alarm_ack,
    output logic        Alarm_hit,
    output logic        Alarm_ring,
`endif
    output logic [23:0] Time_bcd,
    output logic [23:0] Disp_bcd,
    output logic        Pm,
    output logic        Sec_tick,
    output logic        Day_tick,
    output logic        Load_err
);
    localparam int PW = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ - 1);
    localparam logic [23:0] RST_TIME = {16'h0000, 4'(SEC_START / 10), 4'(SEC_START % 10)};

    function automatic logic [7:0] inc60(input logic [7:0] v);
        return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0}) : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] dec60(input logic [7:0] v);
        return v[3:0] == 4'd0 ? (v[7:4] == 4'd0 ? 8'h59 : {v[7:4] - 4'd1, 4'd9}) : {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        return v == 8'h23 ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] dec24(input logic [7:0] v);
        return v == 8'h00 ? 8'h23 : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    logic [PW-1:0] pre, pre_n;
    logic          pend, pend_n;
    logic [7:0]    hh, mm, ss;
    logic          tick, valid, adj, adv, sec_wrap, min_wrap, day_wrap;
    logic [23:0]   tick_time, adj_time, time_n;
    logic [4:0]    hb, hb12;
    logic [7:0]    hour12;

    assign hh = Time_bcd[23:16];
    assign mm = Time_bcd[15:8];
    assign ss = Time_bcd[7:0];

    always_comb begin
        tick      = Run && pre == PRE_MAX;
        valid     = Load_time[3:0] <= 4'd9 && Load_time[7:4] <= 4'd5
                 && Load_time[11:8] <= 4'd9 && Load_time[15:12] <= 4'd5
                 && Load_time[19:16] <= 4'd9
                 && (Load_time[23:20] < 4'd2 || (Load_time[23:20] == 4'd2 && Load_time[19:16] <= 4'd3));
        adj       = !Load && (Inc ^ Dec) && Field_sel != 2'd3;
        // a tick that loses to an adjust is parked in pend and replayed next cycle
        adv       = !Load && !adj && (tick || pend);
        sec_wrap  = ss == 8'h59;
        min_wrap  = mm == 8'h59;
        day_wrap  = sec_wrap && min_wrap && hh == 8'h23;
        tick_time = {sec_wrap && min_wrap ? inc24(hh) : hh, sec_wrap ? inc60(mm) : mm, inc60(ss)};
        adj_time  = Field_sel == 2'd0 ? {hh, mm, Inc ? inc60(ss) : dec60(ss)}
                  : Field_sel == 2'd1 ? {hh, Inc ? inc60(mm) : dec60(mm), ss}
                  : Field_sel == 2'd2 ? {Inc ? inc24(hh) : dec24(hh), mm, ss}
                  : Time_bcd;
        time_n    = Load ? (valid ? Load_time : Time_bcd)
                  : adj ? adj_time
                  : adv ? tick_time
                  : Time_bcd;
        pre_n     = (!Run || (Load && valid) || (adj && Field_sel == 2'd0) || tick) ? '0 : pre + PW'(1);
        pend_n    = Load ? (!valid && pend) : (adj && (pend || tick));
        hb        = 5'(Time_bcd[23:20]) * 5'd10 + 5'(Time_bcd[19:16]);
        hb12      = hb == 5'd0 ? 5'd12 : hb > 5'd12 ? hb - 5'd12 : hb;
        hour12    = hb12 >= 5'd10 ? {4'd1, 4'(hb12 - 5'd10)} : {4'd0, hb12[3:0]};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pre      <= '0;
            pend     <= 1'b0;
            Time_bcd <= RST_TIME;
            Disp_bcd <= RST_TIME;
            Pm       <= 1'b0;
            Sec_tick <= 1'b0;
            Day_tick <= 1'b0;
            Load_err <= 1'b0;
        end else begin
            pre      <= pre_n;
            pend     <= pend_n;
            Time_bcd <= time_n;
            Disp_bcd <= Mode_12h ? {hour12, Time_bcd[15:0]} : Time_bcd;
            Pm       <= hb >= 5'd12;
            Sec_tick <= adv;
            Day_tick <= adv && day_wrap;
            Load_err <= Load && !valid;
        end
    end

`ifdef RTC_COUNTER_ALARM_EN
    logic alarm_match;

    // only time advancing by a tick may fire the alarm, never a load or adjust
    assign alarm_match = adv && Alarm_arm && tick_time == Alarm_time;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Alarm_hit  <= 1'b0;
            Alarm_ring <= 1'b0;
        end else begin
            Alarm_hit  <= alarm_match;
            Alarm_ring <= (!Alarm_arm || Alarm_ack) ? 1'b0 : (alarm_match || Alarm_ring);
        end
    end
`endif

endmodule

// File: tb/tb_rtc_counter.sv
// tb_rtc_counter: scoreboard bench for rtc_counter at CLK_FREQ=10, SEC_START=5.
// Alarm scenario compiles in only when RTC_COUNTER_ALARM_EN is defined.
module tb_rtc_counter;
    localparam int CLK_FREQ  = 10;
    localparam int SEC_START = 5;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Run, Mode_12h, Inc, Dec, Load;
    logic [1:0]  Field_sel;
    logic [23:0] Load_time, Time_bcd, Disp_bcd;
    logic        Pm, Sec_tick, Day_tick, Load_err;
`ifdef RTC_COUNTER_ALARM_EN
    logic [23:0] Alarm_time;
    logic        Alarm_arm, Alarm_ack, Alarm_hit, Alarm_ring;
`endif

    int n_run = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [23:0] t;
        logic        d;
    } exp_t;
    exp_t sb[$];

    rtc_counter #(.CLK_FREQ(CLK_FREQ), .SEC_START(SEC_START)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Mode_12h(Mode_12h),
        .Field_sel(Field_sel), .Inc(Inc), .Dec(Dec), .Load(Load), .Load_time(Load_time),
`ifdef RTC_COUNTER_ALARM_EN
        .Alarm_time(Alarm_time), .Alarm_arm(Alarm_arm), .Alarm_ack(Alarm_ack),
        .Alarm_hit(Alarm_hit), .Alarm_ring(Alarm_ring),
`endif
        .Time_bcd(Time_bcd), .Disp_bcd(Disp_bcd), .Pm(Pm),
        .Sec_tick(Sec_tick), .Day_tick(Day_tick), .Load_err(Load_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // every Sec_tick must match the oldest expected tick result
    always @(negedge Clk) begin
        exp_t e;
        if (Sec_tick === 1'b1) begin
            if (sb.size() == 0) check("sb_unexpected_tick", 32'(Sec_tick), 32'd0);
            else begin
                e = sb.pop_front();
                check("sb_tick_time", 32'(Time_bcd), 32'(e.t));
                check("sb_day_tick", 32'(Day_tick), 32'(e.d));
            end
        end
    end

    logic [27:0] adj_tab [8] = '{
        {2'd1, 1'b1, 1'b0, 24'h000030},
        {2'd2, 1'b0, 1'b1, 24'h230030},
        {2'd3, 1'b1, 1'b0, 24'h230030},
        {2'd1, 1'b1, 1'b1, 24'h230030},
        {2'd0, 1'b0, 1'b1, 24'h230029},
        {2'd2, 1'b1, 1'b0, 24'h000029},
        {2'd0, 1'b1, 1'b0, 24'h000030},
        {2'd1, 1'b0, 1'b1, 24'h005930}
    };
    logic [23:0] bad_tab [4] = '{24'h126000, 24'h240000, 24'h000060, 24'h00000a};
    logic [49:0] disp_tab [6] = '{
        {24'h130500, 1'b1, 24'h010500, 1'b1},
        {24'h001500, 1'b1, 24'h121500, 1'b0},
        {24'h120000, 1'b1, 24'h120000, 1'b1},
        {24'h235900, 1'b1, 24'h115900, 1'b1},
        {24'h090000, 1'b1, 24'h090000, 1'b0},
        {24'h130500, 1'b0, 24'h130500, 1'b1}
    };

    initial begin
        logic [1:0]  f;
        logic        i, d, m, p;
        logic [23:0] t, dx;
        Run = 0; Mode_12h = 0; Field_sel = 2'd3; Inc = 0; Dec = 0; Load = 0; Load_time = '0;
`ifdef RTC_COUNTER_ALARM_EN
        Alarm_time = '0; Alarm_arm = 0; Alarm_ack = 0;
`endif
        #1 Reset_n = 0;
        cyc(2);
        check("rst_time", 32'(Time_bcd), 32'h000005);
        check("rst_disp", 32'(Disp_bcd), 32'h000005);
        check("rst_pm", 32'(Pm), 32'd0);
        check("rst_pulses", 32'({Sec_tick, Day_tick, Load_err}), 32'd0);
        Reset_n = 1;
        cyc(25);
        check("run0_hold", 32'(Time_bcd), 32'h000005);

        sb.push_back('{24'h235959, 1'b0});
        sb.push_back('{24'h000000, 1'b1});
        Load_time = 24'h235958; Load = 1; Run = 1;
        cyc(1);
        Load = 0;
        check("load_ok", 32'(Time_bcd), 32'h235958);
        for (int k = 0; k < 40 && sb.size() != 0; k++) cyc(1);
        Run = 0;
        check("wrap_drained", 32'(sb.size()), 32'd0);
        cyc(1);
        check("wrap_time", 32'(Time_bcd), 32'h000000);
        check("wrap_disp", 32'(Disp_bcd), 32'h000000);
        check("wrap_day_pulse", 32'(Day_tick), 32'd0);

        Load_time = 24'h005930; Load = 1;
        cyc(1);
        Load = 0;
        for (int k = 0; k < 8; k++) begin
            {f, i, d, t} = adj_tab[k];
            Field_sel = f; Inc = i; Dec = d;
            cyc(1);
            Inc = 0; Dec = 0;
            check($sformatf("adjust_%0d", k), 32'(Time_bcd), 32'(t));
        end

        Load_time = 24'h102030; Load = 1; Run = 1;
        cyc(1);
        Load = 0;
        cyc(9);
        Field_sel = 2'd1; Inc = 1;
        sb.push_back('{24'h102131, 1'b0});
        cyc(1);
        Inc = 0;
        check("defer_adjust", 32'(Time_bcd), 32'h102130);
        check("defer_no_sec", 32'(Sec_tick), 32'd0);
        cyc(1);
        Run = 0;
        check("defer_tick", 32'(Time_bcd), 32'h102131);
        check("defer_sec", 32'(Sec_tick), 32'd1);

        for (int k = 0; k < 4; k++) begin
            Load_time = bad_tab[k]; Load = 1;
            cyc(1);
            Load = 0;
            check($sformatf("bad_err_%0d", k), 32'(Load_err), 32'd1);
            check($sformatf("bad_keep_%0d", k), 32'(Time_bcd), 32'h102131);
            cyc(1);
            check($sformatf("bad_err_clr_%0d", k), 32'(Load_err), 32'd0);
        end

        for (int k = 0; k < 6; k++) begin
            {t, m, dx, p} = disp_tab[k];
            Load_time = t; Mode_12h = m; Load = 1;
            cyc(1);
            Load = 0;
            check($sformatf("disp_load_%0d", k), 32'({Load_err, Time_bcd}), 32'(t));
            cyc(1);
            check($sformatf("disp_bcd_%0d", k), 32'(Disp_bcd), 32'(dx));
            check($sformatf("disp_pm_%0d", k), 32'(Pm), 32'(p));
        end

        Mode_12h = 0;
        Load_time = 24'h050607; Load = 1; Run = 1;
        cyc(1);
        Load = 0;
        cyc(4);
        #2 Reset_n = 0;
        #1;
        check("async_rst_time", 32'(Time_bcd), 32'h000005);
        check("async_rst_disp", 32'(Disp_bcd), 32'h000005);
        check("async_rst_pulses", 32'({Sec_tick, Day_tick, Load_err, Pm}), 32'd0);
        cyc(1);
        sb.push_back('{24'h000006, 1'b0});
`ifdef RTC_COUNTER_ALARM_EN
        sb.push_back('{24'h000007, 1'b0});
        Alarm_time = 24'h000007; Alarm_arm = 1;
`endif
        Reset_n = 1;
`ifdef RTC_COUNTER_ALARM_EN
        begin
            int k;
            for (k = 0; k < 40 && Alarm_hit !== 1'b1; k++) cyc(1);
            check("alarm_timeout", 32'(k < 40), 32'd1);
        end
        check("alarm_hit_time", 32'(Time_bcd), 32'h000007);
        check("alarm_ring_set", 32'(Alarm_ring), 32'd1);
        cyc(3);
        check("alarm_hit_pulse", 32'(Alarm_hit), 32'd0);
        check("alarm_ring_hold", 32'(Alarm_ring), 32'd1);
        Alarm_ack = 1;
        cyc(1);
        Alarm_ack = 0;
        check("alarm_ack", 32'(Alarm_ring), 32'd0);
`endif
        for (int k = 0; k < 40 && sb.size() != 0; k++) cyc(1);
        Run = 0;
        cyc(2);
        check("final_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_counter.md
RTC_COUNTER -- requirements
Module: rtc_counter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning Clk cycles per second.
REQ-002 SHALL have parameter SEC_START, default 0, meaning the seconds value loaded at reset (binary, 0..59).
REQ-003 SHALL have port Clk, input, 1 bit, the single clock.
REQ-004 SHALL have port Reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port Run, input, 1 bit: 1 lets time advance, 0 freezes it.
REQ-006 SHALL have port Mode_12h, input, 1 bit: selects the 12 h display format.
REQ-007 SHALL have port Field_sel, input, 2 bits: 0 sec, 1 min, 2 hour, 3 none.
REQ-008 SHALL have ports Inc and Dec, input, 1 bit each, single-cycle adjust pulses.
REQ-009 SHALL have ports Load (input, 1 bit) and Load_time (input, 24 bits, BCD hh:mm:ss).
REQ-010 SHALL have port Time_bcd, output, 24 bits: the 24 h BCD time {H1,H0,M1,M0,S1,S0}.
REQ-011 SHALL have port Disp_bcd, output, 24 bits: the display time in the selected format.
REQ-012 SHALL have port Pm, output, 1 bit: 1 when hours >= 12.
REQ-013 SHALL have ports Sec_tick, Day_tick and Load_err, output, 1 bit each, single-cycle pulses.

Function
REQ-014 SHALL count a prescaler 0..CLK_FREQ-1; the count reaching CLK_FREQ-1 with Run=1 is a tick; Run=0 holds the prescaler at 0.
REQ-015 SHALL, on a tick, add one second with BCD ripple carry in the same cycle (59 s to min, 59 min to hour, 23:59:59 to 00:00:00).
REQ-016 SHALL pulse Sec_tick in the cycle Time_bcd updates from a tick; SHALL pulse Day_tick additionally on 23:59:59 to 00:00:00.
REQ-017 SHALL apply Inc to the selected field only, wrapping within the field (59 to 00, 23 to 00), with no carry into neighbouring fields.
REQ-018 SHALL apply Dec to the selected field only, wrapping within the field (00 to 59, 00 to 23), with no borrow.
REQ-019 SHALL make no change when Inc and Dec are both 1 or Field_sel=3.
REQ-020 SHALL clear the prescaler on any seconds-field adjust.
REQ-021 SHALL use priority Load > Inc/Dec > tick.
REQ-022 SHALL, when a tick coincides with Load, drop the tick.
REQ-023 SHALL, when a tick coincides with Inc/Dec, hold the tick in one pending bit and apply it the next cycle; Sec_tick SHALL follow that deferral.
REQ-024 SHALL, on Load, validate Load_time (each digit 0..9, S1/M1 <= 5, hours <= 23).
REQ-025 SHALL, if Load_time is valid, load it and clear the prescaler and pending bit.
REQ-026 SHALL, if Load_time is invalid, keep the time unchanged and pulse Load_err the next cycle.
REQ-027 SHALL register Time_bcd; it updates one cycle after the causing event.
REQ-028 SHALL register Disp_bcd and Pm one cycle after Time_bcd.
REQ-029 SHALL, with Mode_12h=1, display hour 00 as 12 and hours 13..23 as 01..11; with Mode_12h=0, Disp_bcd SHALL equal Time_bcd delayed one cycle.
REQ-030 SHALL give Pm the same value in both Mode_12h settings.

Reset
REQ-031 SHALL, while Reset_n=0, set Time_bcd to 00:00:SEC_START (BCD); the prescaler, pending bit and all pulse outputs to 0; Disp_bcd to the 24 h value; Pm to 0.
REQ-032 SHALL take effect asynchronously, mid-tick or mid-adjust, discarding any pending tick.

Configuration
REQ-033 SHALL, with macro RTC_COUNTER_ALARM_EN defined, add inputs Alarm_time (24 bits BCD), Alarm_arm and Alarm_ack, and outputs Alarm_hit (pulse) and Alarm_ring (level).
REQ-034 SHALL, with the macro defined, pulse Alarm_hit and set Alarm_ring when a tick makes Time_bcd equal Alarm_time while Alarm_arm=1.
REQ-035 SHALL, with the macro defined, clear Alarm_ring on Alarm_ack=1 or Alarm_arm=0; Load or Inc/Dec matches SHALL NOT fire.
REQ-036 SHALL, without the macro, omit the alarm ports and logic entirely.

Verification (CLK_FREQ=10)
REQ-037 Load 23:59:58, Run=1, 20 cycles -> ticks give 23:59:59, then 00:00:00 with Day_tick=1 for one cycle.
REQ-038 Time 00:59:30, Field_sel=1, Inc -> 00:00:30, hours unchanged; Field_sel=2, Dec -> 23:00:30.
REQ-039 Inc in the same cycle as a tick at 10:20:30, Field_sel=1 -> 10:21:30, then 10:21:31 one cycle later.
REQ-040 Load 12:60:00 -> time unchanged, Load_err=1 one cycle; Load 13:05:00 with Mode_12h=1 -> Disp_bcd=01:05:00, Pm=1.
REQ-041 Reset asserted mid-count at 05:06:07 -> Time_bcd=00:00:SEC_START immediately, no pulses.
REQ-042 With RTC_COUNTER_ALARM_EN, Alarm_time 00:00:02, armed, from reset -> Alarm_hit at the second tick; Alarm_ring held until Alarm_ack.
